// File: rtl/alu_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef logic [DATA_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Operation captured at the transfer edge.
  typedef struct packed {
    word_t      a;
    word_t      b;
    logic [2:0] op;
    logic       id;
  } req_t;

  // Occupancy of the ALU for one op: only MUL is multi-cycle.
  function automatic logic [3:0] op_latency(input logic [2:0] op, input logic [3:0] mul_cycles);
    return (op == OP_MUL) ? mul_cycles : 4'd1;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the requesters/consumer and the ALU arbiter.
interface alu_arbiter_if;
  import alu_pkg::*;

  logic [1:0] req_valid;
  logic [1:0] req_ready;
  word_t      req0_data1;
  word_t      req0_data2;
  logic [2:0] req0_ctrl;
  word_t      req1_data1;
  word_t      req1_data2;
  logic [2:0] req1_ctrl;

  logic       resp_valid;
  logic       resp_ready;
  logic       resp_id;
  word_t      resp_data;
  logic       resp_err;

  modport master (
    output req_valid, req0_data1, req0_data2, req0_ctrl,
           req1_data1, req1_data2, req1_ctrl, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req0_data1, req0_data2, req0_ctrl,
           req1_data1, req1_data2, req1_ctrl, resp_ready,
    output req_ready, resp_valid, resp_id, resp_data, resp_err
  );

endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU; unsupported op codes yield zero with err set.
module alu_core
  import alu_pkg::*;
(
  input  word_t      a,
  input  word_t      b,
  input  logic [2:0] op,
  output word_t      result,
  output logic       err
);

  always_comb begin
    result = '0;
    err    = 1'b0;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_SLT:  result = {{(DATA_W-1){1'b0}}, (a < b)};
      OP_MUL:  result = a * b;
      default: err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter in front of a single shared ALU: one op in flight,
// IDLE accepts, EXEC counts down the op latency, RESP holds the result.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int MUL_CYCLES = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_valid_i,
  output logic [1:0] req_ready_o,
  input  word_t      req0_data1_i,
  input  word_t      req0_data2_i,
  input  logic [2:0] req0_ctrl_i,
  input  word_t      req1_data1_i,
  input  word_t      req1_data2_i,
  input  logic [2:0] req1_ctrl_i,
  output logic       resp_valid_o,
  input  logic       resp_ready_i,
  output logic       resp_id_o,
  output word_t      resp_data_o,
  output logic       resp_err_o
);

  state_t     state, state_nxt;
  logic       last_grant;
  logic [1:0] grant;
  logic       xfer;
  logic       xfer_id;
  logic [3:0] cnt;
  logic       expire;
  req_t       sel, cap;
  word_t      alu_res;
  logic       alu_err;

  // Ties go to the requester that did not win last time.
  always_comb begin
    grant = 2'b00;
    case (req_valid_i)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_comb begin
    sel.id = req_ready_o[1];
    if (req_ready_o[1]) begin
      sel.a  = req1_data1_i;
      sel.b  = req1_data2_i;
      sel.op = req1_ctrl_i;
    end else begin
      sel.a  = req0_data1_i;
      sel.b  = req0_data2_i;
      sel.op = req0_ctrl_i;
    end
  end

  assign xfer    = |(req_valid_i & req_ready_o);
  assign xfer_id = req_ready_o[1];
  assign expire  = (state == EXEC) && (cnt == 4'd1);

  always_ff @(posedge clk_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    req_ready_o = 2'b00;
    case (state)
      IDLE: begin
        if (rst_i) req_ready_o = grant;
        if (|grant) state_nxt = EXEC;
      end
      EXEC: if (expire) state_nxt = RESP;
      RESP: if (resp_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt          <= 4'd0;
      last_grant   <= 1'b1;
      cap          <= '0;
      resp_valid_o <= 1'b0;
      resp_data_o  <= '0;
      resp_id_o    <= 1'b0;
      resp_err_o   <= 1'b0;
    end else begin
      if (xfer) begin
        cap        <= sel;
        cnt        <= op_latency(sel.op, 4'(MUL_CYCLES));
        last_grant <= xfer_id;
      end else if (state == EXEC) begin
        cnt <= cnt - 4'd1;
      end
      // RESP always has resp_valid_o high, so resp_ready_i is only seen there.
      if (expire) begin
        resp_valid_o <= 1'b1;
        resp_data_o  <= alu_res;
        resp_id_o    <= cap.id;
        resp_err_o   <= alu_err;
      end else if (state == RESP && resp_ready_i) begin
        resp_valid_o <= 1'b0;
      end
    end
  end

  alu_core u_alu_core (
    .a      (cap.a),
    .b      (cap.b),
    .op     (cap.op),
    .result (alu_res),
    .err    (alu_err)
  );

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed scoreboard bench for alu_arbiter (MUL_CYCLES = 3).
module tb_alu_arbiter;

  typedef struct {
    logic [31:0] data;
    logic        id;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if bus();

  alu_arbiter #(.MUL_CYCLES(3)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (bus.req_valid),
    .req_ready_o  (bus.req_ready),
    .req0_data1_i (bus.req0_data1),
    .req0_data2_i (bus.req0_data2),
    .req0_ctrl_i  (bus.req0_ctrl),
    .req1_data1_i (bus.req1_data1),
    .req1_data2_i (bus.req1_data2),
    .req1_ctrl_i  (bus.req1_ctrl),
    .resp_valid_o (bus.resp_valid),
    .resp_ready_i (bus.resp_ready),
    .resp_id_o    (bus.resp_id),
    .resp_data_o  (bus.resp_data),
    .resp_err_o   (bus.resp_err)
  );

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   xfer_cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] op, input logic id);
    exp_t e;
    e.id  = id;
    e.err = 1'b0;
    case (op)
      3'b000:  e.data = a & b;
      3'b001:  e.data = a | b;
      3'b010:  e.data = a + b;
      3'b110:  e.data = a - b;
      3'b111:  e.data = (a < b) ? 32'd1 : 32'd0;
      3'b011:  e.data = a * b;
      default: begin e.data = 32'd0; e.err = 1'b1; end
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic id, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op);
    if (id) begin
      bus.req1_data1 = a; bus.req1_data2 = b; bus.req1_ctrl = op;
    end else begin
      bus.req0_data1 = a; bus.req0_data2 = b; bus.req0_ctrl = op;
    end
  endtask

  // Present one request, wait for its transfer edge, then scramble the inputs.
  task automatic send(input logic id, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] op);
    bit got = 1'b0;
    drive(id, a, b, op);
    bus.req_valid[id] = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = bus.req_ready[id];
    end
    chk("grant_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
    xfer_cyc = cyc;
    bus.req_valid[id] = 1'b0;
    drive(id, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b100);
    if (got) sb.push_back(model(a, b, op, id));
  endtask

  task automatic check_resp(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({tag, "_data"}, bus.resp_data, e.data);
    chk({tag, "_id"}, 32'(bus.resp_id), 32'(e.id));
    chk({tag, "_err"}, 32'(bus.resp_err), 32'(e.err));
  endtask

  task automatic collect(input string tag, input int lat);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = bus.resp_valid;
    end
    chk({tag, "_resp_seen"}, 32'(seen), 32'd1);
    if (!seen) return;
    chk({tag, "_latency"}, 32'(cyc - xfer_cyc), 32'(lat));
    check_resp(tag);
  endtask

  logic [31:0] ta0 [2] = '{32'hF0F0_1234, 32'd5};
  logic [31:0] tb0 [2] = '{32'h0FF0_FFFF, 32'd7};
  logic [2:0]  to0 [2] = '{3'b000, 3'b110};
  logic [31:0] ta1 [2] = '{32'h1200_0000, 32'h8000_0000};
  logic [31:0] tb1 [2] = '{32'h0034_0056, 32'd1};
  logic [2:0]  to1 [2] = '{3'b001, 3'b111};

  initial begin
    bit          seen;
    logic [1:0]  g;
    int          grants, resps, idx0, idx1;

    bus.req_valid = 2'b00;
    bus.resp_ready = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 3'b000);
    drive(1'b1, 32'd0, 32'd0, 3'b000);

    // Reset held with both requesters valid: no grant, response regs cleared.
    rst = 1'b0;
    bus.req_valid = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_data", bus.resp_data, 32'd0);
    chk("rst_resp_id", 32'(bus.resp_id), 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    bus.req_valid = 2'b00;
    rst = 1'b1;
    @(posedge clk); #1;

    // Single ADD with wrap-around, then MUL latency.
    bus.resp_ready = 1'b1;
    send(1'b0, 32'hFFFF_FFFF, 32'h2, 3'b010);
    collect("add", 1);
    @(posedge clk); #1;
    send(1'b1, 32'h0001_0000, 32'h0001_0001, 3'b011);
    collect("mul", 3);
    @(negedge clk);
    chk("mul_resp_drop", 32'(bus.resp_valid), 32'd0);
    @(posedge clk); #1;

    // Contention: both held valid, grants must alternate 0,1,0,1.
    idx0 = 0; idx1 = 0; grants = 0; resps = 0;
    drive(1'b0, ta0[0], tb0[0], to0[0]);
    drive(1'b1, ta1[0], tb1[0], to1[0]);
    bus.req_valid = 2'b11;
    for (int c = 0; c < 100 && resps < 4; c++) begin
      @(negedge clk);
      chk("ready_not_both", 32'(&bus.req_ready), 32'd0);
      if (bus.resp_valid) begin
        check_resp("cont");
        resps++;
      end
      g = bus.req_ready & bus.req_valid;
      if (g != 2'b00) begin
        chk("grant_order", 32'(g[1]), 32'(grants % 2));
        if (g[1]) sb.push_back(model(ta1[idx1], tb1[idx1], to1[idx1], 1'b1));
        else      sb.push_back(model(ta0[idx0], tb0[idx0], to0[idx0], 1'b0));
        grants++;
      end
      @(posedge clk); #1;
      if (g[0]) begin
        idx0++;
        if (idx0 >= 2) bus.req_valid[0] = 1'b0;
        else drive(1'b0, ta0[idx0], tb0[idx0], to0[idx0]);
      end
      if (g[1]) begin
        idx1++;
        if (idx1 >= 2) bus.req_valid[1] = 1'b0;
        else drive(1'b1, ta1[idx1], tb1[idx1], to1[idx1]);
      end
    end
    chk("cont_grants", 32'(grants), 32'd4);
    chk("cont_resps", 32'(resps), 32'd4);
    bus.req_valid = 2'b00;

    // Backpressure on an SLT while requester 1 waits.
    bus.resp_ready = 1'b0;
    send(1'b0, 32'd3, 32'd7, 3'b111);
    drive(1'b1, 32'hAAAA_5555, 32'hFFFF_0000, 3'b000);
    bus.req_valid[1] = 1'b1;
    collect("slt", 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(bus.resp_valid), 32'd1);
      chk("bp_data", bus.resp_data, 32'd1);
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_released", 32'(bus.resp_valid), 32'd0);
    chk("bp_idle_grant", 32'(bus.req_ready), 32'd2);
    bus.req_valid = 2'b00;
    @(posedge clk); #1;

    // Unsupported op code.
    send(1'b1, 32'h1234, 32'h5678, 3'b101);
    collect("badop", 1);
    @(posedge clk); #1;

    // Reset pulse during a MUL in EXEC: the op vanishes.
    send(1'b0, 32'd6, 32'd7, 3'b011);
    if (sb.size() != 0) void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.resp_valid) seen = 1'b1;
    end
    chk("rst_no_resp", 32'(seen), 32'd0);
    bus.req_valid = 2'b11;
    #1;
    chk("rst_first_grant", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 2'b00;

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
